// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Moore FSM controller for a shared-memory multi-cycle MIPS datapath (one ALU,
// one memory port, one IR). Every datapath mux select and enable is decoded
// from the current state. opcode/funct only pick the ALU operation and the
// DECODE/R_EXEC/MEM_ADDR/BRANCH branches. zero and mem_ready qualify pc_write
// and ir_write in the states that use them.
//
// Parameters
//   MEM_TIMEOUT : max cycles spent in a memory state without mem_ready before
//                 the controller halts with err set.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   opcode      : IR[31:26], valid from DECODE onward
//   funct       : IR[5:0]
//   zero        : ALU zero flag (combinational)
//   mem_ready   : memory completes the current access this cycle
//   pc_write    : PC load enable (jump / taken branch already folded in)
//   i_or_d      : memory address select, 0=PC 1=ALUOut
//   mem_read    : memory read request
//   mem_write   : memory write request
//   ir_write    : IR load enable
//   reg_dst     : register write address, 1=rd 0=rt
//   mem_to_reg  : register write data, 1=MDR 0=ALUOut
//   reg_write   : register file write enable
//   alu_src_a   : 0=PC 1=rs 2=shamt
//   alu_src_b   : 0=rt 1=4 2=sext(imm) 3=sext(imm)<<2
//   alu_ctrl    : 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 sll
//   pc_source   : 0=ALU result 1=ALUOut 2=jump target
//   halted      : high in HALT
//   err         : sticky illegal-instruction / memory-timeout flag
//   state       : current state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       halted,
    output logic       err,
    output logic [3:0] state
);

    // ---------------------------------------------------------------- states
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_R_EXEC   = 4'd2;
    localparam logic [3:0] S_R_WB     = 4'd3;
    localparam logic [3:0] S_I_EXEC   = 4'd4;
    localparam logic [3:0] S_I_WB     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_LW_WB    = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    // ---------------------------------------------------------------- opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1100;

    // ---------------------------------------------------------------- state
    logic [3:0] r_state;
    logic       r_err;
    logic [7:0] r_wait_cnt;     // cycles already spent waiting in this memory state

    logic [3:0] w_next;
    logic       w_err_set;
    logic       w_is_mem;
    logic [8:0] w_wait_now;
    logic       w_timeout;

    // R-type funct decode
    logic       w_r_ok;
    logic [1:0] w_r_src_a;
    logic [3:0] w_r_ctrl;

    // I-type ALU op
    logic [3:0] w_i_ctrl;

    // unqualified (pre-reset-gating) outputs
    logic       w_pc_write, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
    logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_halted;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_pc_source;
    logic [3:0] w_alu_ctrl;

    assign w_is_mem = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                      (r_state == S_MEM_WR);

    // Count including the current cycle: the 1st waiting cycle counts as 1,
    // so a memory state asserts its request for at most MEM_TIMEOUT cycles,
    // and mem_ready on the cycle the count hits MEM_TIMEOUT still succeeds.
    assign w_wait_now = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout  = w_is_mem && !mem_ready &&
                        (w_wait_now >= {1'b0, MEM_TIMEOUT});

    always_comb begin
        w_r_ok    = 1'b1;
        w_r_src_a = 2'd1;
        w_r_ctrl  = ALU_ADD;
        case (funct)
            FN_ADD:  w_r_ctrl = ALU_ADD;
            FN_SUB:  w_r_ctrl = ALU_SUB;
            FN_AND:  w_r_ctrl = ALU_AND;
            FN_OR:   w_r_ctrl = ALU_OR;
            FN_SLT:  w_r_ctrl = ALU_SLT;
            FN_SLL: begin
                w_r_src_a = 2'd2;
                w_r_ctrl  = ALU_SLL;
            end
            default: begin
                w_r_ok    = 1'b0;
                w_r_src_a = 2'd0;
                w_r_ctrl  = ALU_ADD;
            end
        endcase
    end

    always_comb begin
        case (opcode)
            OP_ANDI: w_i_ctrl = ALU_AND;
            OP_ORI:  w_i_ctrl = ALU_OR;
            default: w_i_ctrl = ALU_ADD;
        endcase
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) begin w_next = S_HALT; w_err_set = 1'b1; end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:               w_next = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
                    OP_LW, OP_SW:           w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:         w_next = S_BRANCH;
                    OP_J:                   w_next = S_JUMP;
                    OP_HALT:                w_next = S_HALT;
                    default: begin
                        w_next    = S_HALT;
                        w_err_set = 1'b1;
                    end
                endcase
            end
            S_R_EXEC: begin
                if (w_r_ok) w_next = S_R_WB;
                else begin w_next = S_HALT; w_err_set = 1'b1; end
            end
            S_R_WB:   w_next = S_FETCH;
            S_I_EXEC: w_next = S_I_WB;
            S_I_WB:   w_next = S_FETCH;
            S_MEM_ADDR: begin
                // opcode is held by the IR, so only lw/sw can arrive here
                if (opcode == OP_LW)      w_next = S_MEM_RD;
                else if (opcode == OP_SW) w_next = S_MEM_WR;
                else begin w_next = S_HALT; w_err_set = 1'b1; end
            end
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_LW_WB;
                else if (w_timeout) begin w_next = S_HALT; w_err_set = 1'b1; end
            end
            S_LW_WB: w_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) begin w_next = S_HALT; w_err_set = 1'b1; end
            end
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default: begin
                // codes 13-15 are unreachable; treat as a corrupted state
                w_next    = S_HALT;
                w_err_set = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_err      <= 1'b0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_err_set)
                r_err <= 1'b1;
            // any state change clears the count, so every memory state is
            // entered with a fresh budget
            if (w_is_mem && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        w_pc_write   = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'd0;
        w_alu_src_b  = 2'd0;
        w_alu_ctrl   = 4'b0000;
        w_pc_source  = 2'd0;
        w_halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'd1;
                w_alu_ctrl  = ALU_ADD;
                // PC+4 and IR load only commit on the cycle memory delivers
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b = 2'd3;
                w_alu_ctrl  = ALU_ADD;
            end
            S_R_EXEC: begin
                w_alu_src_a = w_r_src_a;
                w_alu_ctrl  = w_r_ctrl;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_I_EXEC, S_MEM_ADDR: begin
                w_alu_src_a = 2'd1;
                w_alu_src_b = 2'd2;
                w_alu_ctrl  = (r_state == S_I_EXEC) ? w_i_ctrl : ALU_ADD;
            end
            S_I_WB: w_reg_write = 1'b1;
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'd1;
                w_alu_ctrl  = ALU_SUB;
                w_pc_source = 2'd1;
                w_pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                w_pc_source = 2'd2;
                w_pc_write  = 1'b1;
            end
            S_HALT: w_halted = 1'b1;
            default: ;
        endcase
    end

    // While reset is held the register already sits in FETCH; gating with
    // rst_n keeps FETCH's read request (and any in-flight write) off until
    // reset is released, without waiting for a clock edge.
    assign pc_write   = rst_n & w_pc_write;
    assign i_or_d     = rst_n & w_i_or_d;
    assign mem_read   = rst_n & w_mem_read;
    assign mem_write  = rst_n & w_mem_write;
    assign ir_write   = rst_n & w_ir_write;
    assign reg_dst    = rst_n & w_reg_dst;
    assign mem_to_reg = rst_n & w_mem_to_reg;
    assign reg_write  = rst_n & w_reg_write;
    assign alu_src_a  = {2{rst_n}} & w_alu_src_a;
    assign alu_src_b  = {2{rst_n}} & w_alu_src_b;
    assign alu_ctrl   = {4{rst_n}} & w_alu_ctrl;
    assign pc_source  = {2{rst_n}} & w_pc_source;
    assign halted     = rst_n & w_halted;
    assign err        = r_err;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b1;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, halted, err;
    logic [1:0] alu_src_a, alu_src_b, pc_source;
    logic [3:0] alu_ctrl, state;

    multicycle_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_source(pc_source), .halted(halted),
        .err(err), .state(state)
    );

    always #5 clk = ~clk;   // negedge at 5, posedge at 10, ...

    typedef struct packed {
        logic       pw, iod, mr, mw, irw, rd, m2r, rw;
        logic [1:0] sa, sb;
        logic [3:0] ac;
        logic [1:0] ps;
        logic       h, er;
        logic [3:0] st;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string name;
    } item_t;

    obs_t  obs;
    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    assign obs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
                  pc_source, halted, err, state};

    function automatic obs_t e(input logic [3:0] st,
                               input logic pw, input logic iod, input logic mr,
                               input logic mw, input logic irw, input logic rd,
                               input logic m2r, input logic rw,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [3:0] ac, input logic [1:0] ps,
                               input logic h, input logic er);
        obs_t o;
        o.pw = pw; o.iod = iod; o.mr = mr; o.mw = mw; o.irw = irw;
        o.rd = rd; o.m2r = m2r; o.rw = rw; o.sa = sa; o.sb = sb;
        o.ac = ac; o.ps = ps; o.h = h; o.er = er; o.st = st;
        return o;
    endfunction

    // Monitor: every cycle, compare the DUT outputs mid-cycle against the
    // oldest expectation the stimulus queued for that cycle.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                checks++;
                if (obs !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h (t=%0t)",
                             it.name, obs, it.exp, $time);
                end
            end
        end
    end

    task automatic step(input string nm, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy,
                        input obs_t ex);
        item_t it;
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        it.exp = ex; it.name = nm;
        q.push_back(it);
        @(posedge clk); #1;
    endtask

    initial begin
        obs_t X0, XFW, XFR, XDEC, XRADD, XRSLL, XRWB, XIOR, XIWB, XMA;
        obs_t XMRD, XLWB, XMWR, XBEQ, XBNE, XJMP, XHLT_E;
        //        st   pw iod mr mw irw rd m2r rw  sa  sb  ac       ps  h  er
        X0     = e(4'd0, 0,0,0,0,0, 0,0,0, 2'd0,2'd0,4'b0000,2'd0,0,0);
        XFW    = e(4'd0, 0,0,1,0,0, 0,0,0, 2'd0,2'd1,4'b0010,2'd0,0,0);
        XFR    = e(4'd0, 1,0,1,0,1, 0,0,0, 2'd0,2'd1,4'b0010,2'd0,0,0);
        XDEC   = e(4'd1, 0,0,0,0,0, 0,0,0, 2'd0,2'd3,4'b0010,2'd0,0,0);
        XRADD  = e(4'd2, 0,0,0,0,0, 0,0,0, 2'd1,2'd0,4'b0010,2'd0,0,0);
        XRSLL  = e(4'd2, 0,0,0,0,0, 0,0,0, 2'd2,2'd0,4'b1100,2'd0,0,0);
        XRWB   = e(4'd3, 0,0,0,0,0, 1,0,1, 2'd0,2'd0,4'b0000,2'd0,0,0);
        XIOR   = e(4'd4, 0,0,0,0,0, 0,0,0, 2'd1,2'd2,4'b0001,2'd0,0,0);
        XIWB   = e(4'd5, 0,0,0,0,0, 0,0,1, 2'd0,2'd0,4'b0000,2'd0,0,0);
        XMA    = e(4'd6, 0,0,0,0,0, 0,0,0, 2'd1,2'd2,4'b0010,2'd0,0,0);
        XMRD   = e(4'd7, 0,1,1,0,0, 0,0,0, 2'd0,2'd0,4'b0000,2'd0,0,0);
        XLWB   = e(4'd8, 0,0,0,0,0, 0,1,1, 2'd0,2'd0,4'b0000,2'd0,0,0);
        XMWR   = e(4'd9, 0,1,0,1,0, 0,0,0, 2'd0,2'd0,4'b0000,2'd0,0,0);
        XBEQ   = e(4'd10,1,0,0,0,0, 0,0,0, 2'd1,2'd0,4'b0110,2'd1,0,0);
        XBNE   = e(4'd10,0,0,0,0,0, 0,0,0, 2'd1,2'd0,4'b0110,2'd1,0,0);
        XJMP   = e(4'd11,1,0,0,0,0, 0,0,0, 2'd0,2'd0,4'b0000,2'd2,0,0);
        XHLT_E = e(4'd12,0,0,0,0,0, 0,0,0, 2'd0,2'd0,4'b0000,2'd0,1,1);

        // reset held: everything off, state FETCH
        step("reset_a", 6'h00, 6'h00, 0, 1, X0);
        step("reset_b", 6'h00, 6'h00, 0, 1, X0);
        rst_n = 1'b1;

        // add: 4 cycles, ready immediately
        step("add_fetch",  6'h00, 6'h20, 0, 1, XFR);
        step("add_decode", 6'h00, 6'h20, 0, 1, XDEC);
        step("add_exec",   6'h00, 6'h20, 0, 1, XRADD);
        step("add_wb",     6'h00, 6'h20, 0, 1, XRWB);

        // lw: 3 wait cycles in FETCH and MEM_RD, ready on the 4th (== timeout)
        for (int i = 0; i < 3; i++) step("lw_fetch_wait", 6'h23, 6'h00, 0, 0, XFW);
        step("lw_fetch_rdy", 6'h23, 6'h00, 0, 1, XFR);
        step("lw_decode",    6'h23, 6'h00, 0, 0, XDEC);
        step("lw_addr",      6'h23, 6'h00, 0, 0, XMA);
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 6'h23, 6'h00, 0, 0, XMRD);
        step("lw_rd_rdy",    6'h23, 6'h00, 0, 1, XMRD);
        step("lw_wb",        6'h23, 6'h00, 0, 1, XLWB);

        // beq taken, bne not taken (zero=1 for both)
        step("beq_fetch",  6'h04, 6'h00, 1, 1, XFR);
        step("beq_decode", 6'h04, 6'h00, 1, 1, XDEC);
        step("beq_branch", 6'h04, 6'h00, 1, 1, XBEQ);
        step("bne_fetch",  6'h05, 6'h00, 1, 1, XFR);
        step("bne_decode", 6'h05, 6'h00, 1, 1, XDEC);
        step("bne_branch", 6'h05, 6'h00, 1, 1, XBNE);

        // j and ori
        step("j_fetch",    6'h02, 6'h00, 0, 1, XFR);
        step("j_decode",   6'h02, 6'h00, 0, 1, XDEC);
        step("j_jump",     6'h02, 6'h00, 0, 1, XJMP);
        step("ori_fetch",  6'h0D, 6'h00, 0, 1, XFR);
        step("ori_decode", 6'h0D, 6'h00, 0, 1, XDEC);
        step("ori_exec",   6'h0D, 6'h00, 0, 1, XIOR);
        step("ori_wb",     6'h0D, 6'h00, 0, 1, XIWB);

        // sll
        step("sll_fetch",  6'h00, 6'h00, 0, 1, XFR);
        step("sll_decode", 6'h00, 6'h00, 0, 1, XDEC);
        step("sll_exec",   6'h00, 6'h00, 0, 1, XRSLL);
        step("sll_wb",     6'h00, 6'h00, 0, 1, XRWB);

        // illegal opcode -> HALT with err; mem_ready ignored there
        step("ill_fetch",  6'h1F, 6'h00, 0, 1, XFR);
        step("ill_decode", 6'h1F, 6'h00, 0, 1, XDEC);
        step("ill_halt_a", 6'h1F, 6'h00, 0, 1, XHLT_E);
        step("ill_halt_b", 6'h1F, 6'h00, 0, 1, XHLT_E);

        // reset clears err
        rst_n = 1'b0;
        step("rst_clr_a", 6'h00, 6'h00, 0, 0, X0);
        step("rst_clr_b", 6'h00, 6'h00, 0, 0, X0);
        rst_n = 1'b1;

        // sw timeout: 4 waiting cycles with mem_write, then HALT err
        step("to_fetch",  6'h2B, 6'h00, 0, 1, XFR);
        step("to_decode", 6'h2B, 6'h00, 0, 0, XDEC);
        step("to_addr",   6'h2B, 6'h00, 0, 0, XMA);
        for (int i = 0; i < 4; i++) step("to_wr_wait", 6'h2B, 6'h00, 0, 0, XMWR);
        step("to_halt",   6'h2B, 6'h00, 0, 0, XHLT_E);

        rst_n = 1'b0;
        step("rst2_a", 6'h00, 6'h00, 0, 0, X0);
        rst_n = 1'b1;

        // reset asserted mid-write: mem_write drops before any clock edge
        step("rm_fetch",  6'h2B, 6'h00, 0, 1, XFR);
        step("rm_decode", 6'h2B, 6'h00, 0, 0, XDEC);
        step("rm_addr",   6'h2B, 6'h00, 0, 0, XMA);
        step("rm_wr_a",   6'h2B, 6'h00, 0, 0, XMWR);
        step("rm_wr_b",   6'h2B, 6'h00, 0, 0, XMWR);
        rst_n = 1'b0;
        step("rm_async",  6'h2B, 6'h00, 0, 0, X0);
        step("rm_held",   6'h2B, 6'h00, 0, 0, X0);
        rst_n = 1'b1;
        step("rm_fetch_after", 6'h00, 6'h20, 0, 0, XFW);

        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
